fpall_shared_combine: RTL and testbench

//  Shared floating-point arithmetic unit: ADD, SUB and MUL on IEEE-754 binary32,
//  or on binary16 in the low half-word, selected per cycle by fmt/opcode.

---
 rtl/fpall_shared_combine.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_fpall_shared_combine.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fpall_shared_combine.sv
// -----------------------------------------------------------------------------
// fpall_shared_combine
//   Shared floating-point ADD / SUB / MUL unit for the FPALL execution cluster.
//   Operates on IEEE-754 binary32, or on binary16 held in the low half-word.
//   Both formats go through one significand datapath: FP16 significands are
//   left-aligned inside the 24-bit FP32 significand field, so the multiplier,
//   aligner, adder, normaliser and rounder are shared. Only the rounding
//   position, bias and exponent limits change with the format.
//   Zero/subnormal inputs are treated as signed zero, and tiny results are
//   flushed to signed zero. Rounding is round-to-nearest-even. No flags.
//
// Ports
//   clk     in  1         rising-edge clock
//   rst_n   in  1         asynchronous active-low reset, clears R
//   fmt     in  fp_fmt_e  FMT_FP32 / FMT_FP16 (other codes act as FP32)
//   opcode  in  fp_op_e   OP_ADD / OP_SUB / OP_MUL (other codes give R = 0)
//   X       in  32        operand A (FP16 uses X[15:0])
//   Y       in  32        operand B (FP16 uses Y[15:0])
//   R       out 32        registered result, one cycle after the inputs
//                         (FP16: R[15:0], R[31:16] = 0)
// -----------------------------------------------------------------------------
package FPALL_pkg;

  typedef enum logic [1:0] {
    FMT_FP32 = 2'd0,
    FMT_FP16 = 2'd1
  } fp_fmt_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } fp_op_e;

  // Format-neutral operand. exp is the biased exponent (FP16 zero-extended);
  // sig carries the implicit one, with FP16 fractions left-aligned so both
  // formats share every significand operation.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        zero;
    logic        inf;
    logic        nan;
  } fp_operand_t;

endpackage

module fpall_shared_combine
  import FPALL_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  fp_fmt_e     fmt,
  input  fp_op_e      opcode,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic [31:0] R
);

  // Width of the normalised significand handed to the rounder: leading one
  // at bit 50, 24 kept bits, and enough bits below for guard/round/sticky.
  localparam int NW = 51;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic fp_operand_t unpack(input logic half, input logic [31:0] v);
    fp_operand_t o;
    logic [22:0] frac;
    logic [7:0]  emax;
    if (half) begin
      o.sign = v[15];
      o.exp  = {3'b000, v[14:10]};
      frac   = {v[9:0], 13'd0};
      emax   = 8'd31;
    end else begin
      o.sign = v[31];
      o.exp  = v[30:23];
      frac   = v[22:0];
      emax   = 8'd255;
    end
    o.sig  = {1'b1, frac};
    o.zero = (o.exp == 8'd0);          // subnormals are taken as zero
    o.inf  = (o.exp == emax) && (frac == 23'd0);
    o.nan  = (o.exp == emax) && (frac != 23'd0);
    return o;
  endfunction

  // frac is left-aligned: FP16 takes its 10 fraction bits from frac[22:13].
  function automatic logic [31:0] pack(input logic half, input logic sign,
                                       input logic [7:0] e, input logic [22:0] frac);
    return half ? {16'h0000, sign, e[4:0], frac[22:13]} : {sign, e, frac};
  endfunction

  // Leading-zero count; an all-zero input returns NW.
  function automatic logic [5:0] lzc(input logic [NW-1:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'(NW);
    found = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(NW - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand decode
  // ---------------------------------------------------------------------------
  logic               is16;
  logic               is_mul;
  logic               is_addsub;
  logic [7:0]         exp_max;
  logic signed [11:0] bias;
  logic [31:0]        qnan;
  fp_operand_t        opx;
  fp_operand_t        opy;
  logic               y_sign;          // sign of Y after SUB inversion
  logic signed [11:0] ex_u;            // unbiased exponents
  logic signed [11:0] ey_u;

  assign is16      = (fmt == FMT_FP16);
  assign is_mul    = (opcode == OP_MUL);
  assign is_addsub = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign exp_max   = is16 ? 8'd31 : 8'd255;
  assign bias      = is16 ? 12'sd15 : 12'sd127;
  assign qnan      = is16 ? 32'h0000_7E00 : 32'h7FC0_0000;

  assign opx    = unpack(is16, X);
  assign opy    = unpack(is16, Y);
  assign y_sign = opy.sign ^ (opcode == OP_SUB);
  assign ex_u   = $signed({4'd0, opx.exp}) - bias;
  assign ey_u   = $signed({4'd0, opy.exp}) - bias;

  // ---------------------------------------------------------------------------
  // Multiply path
  // ---------------------------------------------------------------------------
  logic [47:0]        prod;
  logic               mul_sign;
  logic [NW-1:0]      mul_norm;
  logic signed [11:0] mul_exp;

  assign prod     = opx.sig * opy.sig;
  assign mul_sign = opx.sign ^ opy.sign;
  // Product lies in [1,4): a set bit 47 means >= 2, which is the 1-bit right
  // shift plus exponent increment; otherwise drop the empty top bit.
  assign mul_norm = prod[47] ? {prod, 3'b000} : {prod[46:0], 4'b0000};
  assign mul_exp  = ex_u + ey_u + $signed({11'd0, prod[47]});

  // ---------------------------------------------------------------------------
  // Add / subtract path
  // ---------------------------------------------------------------------------
  logic               swap;
  logic               big_sign;
  logic               eff_sub;
  logic [7:0]         big_exp;
  logic [7:0]         small_exp;
  logic [7:0]         exp_diff;
  logic [23:0]        big_sig;
  logic [23:0]        small_sig;
  logic signed [11:0] big_exp_u;
  logic [49:0]        big_w;
  logic [49:0]        small_w;
  logic [49:0]        small_al;
  logic [49:0]        lost_mask;
  logic               sticky;
  logic [NW-1:0]      sum;
  logic [5:0]         lz;
  logic [NW-1:0]      add_norm;
  logic signed [11:0] add_exp;

  // NOTE: every variable driven here gets a value before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    sticky    = 1'b0;
    small_al  = '0;
    // Magnitude order on the raw {exp, significand} fields so |A| >= |B|.
    swap      = {opy.exp, opy.sig} > {opx.exp, opx.sig};
    big_sign  = swap ? y_sign   : opx.sign;
    big_exp   = swap ? opy.exp  : opx.exp;
    big_sig   = swap ? opy.sig  : opx.sig;
    big_exp_u = swap ? ey_u     : ex_u;
    small_exp = swap ? opx.exp  : opy.exp;
    small_sig = swap ? opx.sig  : opy.sig;
    eff_sub   = opx.sign ^ y_sign;
    exp_diff  = big_exp - small_exp;

    // 26 zero bits below each significand keep alignment exact for small
    // shifts; anything shifted further out is jammed into bit 0 as sticky.
    big_w     = {big_sig, 26'd0};
    small_w   = {small_sig, 26'd0};
    lost_mask = ~({50{1'b1}} << exp_diff[5:0]);
    if (exp_diff >= 8'd50) begin
      sticky   = 1'b1;
      small_al = {49'd0, sticky};
    end else begin
      sticky   = |(small_w & lost_mask);
      small_al = (small_w >> exp_diff[5:0]) | {49'd0, sticky};
    end

    sum = eff_sub ? ({1'b0, big_w} - {1'b0, small_al})
                  : ({1'b0, big_w} + {1'b0, small_al});

    // Bit 50 is the carry position: lz = 0 is the carry case (1-bit right
    // shift relative to the operands), lz >= 2 is cancellation.
    lz       = lzc(sum);
    add_norm = sum << lz;
    add_exp  = big_exp_u + 12'sd1 - $signed({6'd0, lz});
  end

  // ---------------------------------------------------------------------------
  // Shared round-to-nearest-even and repack
  // ---------------------------------------------------------------------------
  logic               r_sign;
  logic signed [11:0] r_exp;
  logic signed [11:0] r_exp_b;
  logic [NW-1:0]      r_norm;
  logic [23:0]        keep;
  logic               guard;
  logic               round_bit;
  logic               sticky_bit;
  logic               inc;
  logic [24:0]        rounded;
  logic               carry;
  logic [22:0]        r_frac;
  logic [31:0]        round_res;

  always_comb begin
    r_sign = is_mul ? mul_sign : big_sign;
    r_exp  = is_mul ? mul_exp  : add_exp;
    r_norm = is_mul ? mul_norm : add_norm;

    if (is16) begin
      keep       = {13'd0, r_norm[50:40]};
      guard      = r_norm[39];
      round_bit  = r_norm[38];
      sticky_bit = |r_norm[37:0];
    end else begin
      keep       = r_norm[50:27];
      guard      = r_norm[26];
      round_bit  = r_norm[25];
      sticky_bit = |r_norm[24:0];
    end

    inc     = guard & (round_bit | sticky_bit | keep[0]);
    rounded = {1'b0, keep} + {24'd0, inc};
    // A carry out leaves the fraction bits all zero, so only the exponent moves.
    carry   = is16 ? rounded[11] : rounded[24];
    r_frac  = is16 ? {rounded[9:0], 13'd0} : rounded[22:0];
    r_exp_b = r_exp + bias + $signed({11'd0, carry});

    if (r_exp_b >= $signed({4'd0, exp_max})) begin
      round_res = pack(is16, r_sign, exp_max, 23'd0);
    end else if (r_exp_b <= 12'sd0) begin
      round_res = pack(is16, r_sign, 8'd0, 23'd0);
    end else begin
      round_res = pack(is16, r_sign, r_exp_b[7:0], r_frac);
    end
  end

  // ---------------------------------------------------------------------------
  // Special-case selection
  // ---------------------------------------------------------------------------
  logic [31:0] r_next;

  always_comb begin
    r_next = '0;
    if (is_mul) begin
      if (opx.nan || opy.nan || (opx.inf && opy.zero) || (opy.inf && opx.zero)) begin
        r_next = qnan;
      end else if (opx.inf || opy.inf) begin
        r_next = pack(is16, mul_sign, exp_max, 23'd0);
      end else if (opx.zero || opy.zero) begin
        r_next = pack(is16, mul_sign, 8'd0, 23'd0);
      end else begin
        r_next = round_res;
      end
    end else if (is_addsub) begin
      if (opx.nan || opy.nan || (opx.inf && opy.inf && (opx.sign != y_sign))) begin
        r_next = qnan;
      end else if (opx.inf) begin
        r_next = pack(is16, opx.sign, exp_max, 23'd0);
      end else if (opy.inf) begin
        r_next = pack(is16, y_sign, exp_max, 23'd0);
      end else if (opx.zero && opy.zero) begin
        // Under RNE the sum of zeros is -0 only when both are -0.
        r_next = pack(is16, opx.sign & y_sign, 8'd0, 23'd0);
      end else if (opx.zero) begin
        r_next = pack(is16, y_sign, opy.exp, opy.sig[22:0]);
      end else if (opy.zero) begin
        r_next = pack(is16, opx.sign, opx.exp, opx.sig[22:0]);
      end else if (sum == '0) begin
        r_next = '0;                   // exact cancellation is +0
      end else begin
        r_next = round_res;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R <= '0;
    end else begin
      R <= r_next;
    end
  end

endmodule

// File: tb/tb_fpall_shared_combine.sv
// -----------------------------------------------------------------------------
// tb_fpall_shared_combine
//   Scoreboard bench for fpall_shared_combine. The driver applies one
//   operation per falling edge and queues its hand-computed result; a
//   separate monitor pops one entry just after each rising edge and compares
//   it against R. Random FP32 multiplies use an integer reference model.
// -----------------------------------------------------------------------------
module tb_fpall_shared_combine;
  import FPALL_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  fp_fmt_e     fmt   = FMT_FP32;
  fp_op_e      opcode = OP_ADD;
  logic [31:0] X = '0;
  logic [31:0] Y = '0;
  logic [31:0] R;

  always #5 clk = ~clk;

  fpall_shared_combine dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .fmt    (fmt),
    .opcode (opcode),
    .X      (X),
    .Y      (Y),
    .R      (R)
  );

  typedef struct {
    logic [31:0] want;
    string       tag;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: R=%08h expected %08h", tag, got, want);
    end
  endtask

  // Apply inputs now and queue the expected result of the next rising edge.
  task automatic drive_push(input fp_fmt_e f, input fp_op_e op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] want, input string tag);
    sb_entry_t e;
    fmt    = f;
    opcode = op;
    X      = a;
    Y      = b;
    e.want = want;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic issue(input fp_fmt_e f, input fp_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] want, input string tag);
    @(negedge clk);
    drive_push(f, op, a, b, want, tag);
  endtask

  // Reference binary32 multiply for normal operands with a normal result:
  // exact 48-bit product, then RNE on the integer remainder.
  function automatic logic [31:0] ref_mul32(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, p, keep, rem, half;
    int e, sh;
    ma = 64'(1) << 23 | 64'(a[22:0]);
    mb = 64'(1) << 23 | 64'(b[22:0]);
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end else begin
      sh = 23;
    end
    keep = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep++;
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1;
      e++;
    end
    return {a[31] ^ b[31], 8'(e), keep[22:0]};
  endfunction

  // Monitor: one result per rising edge whenever an expectation is queued.
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, R, e.want);
      end
    end
  end

  // Driver
  initial begin
    logic [31:0] a, b;

    rst_n = 1'b0;
    #2;
    check("reset_state", R, 32'h0);
    issue(FMT_FP32, OP_MUL, 32'h4040_0000, 32'h4000_0000, 32'h0, "held_in_reset");

    @(negedge clk);
    rst_n = 1'b1;
    drive_push(FMT_FP32, OP_MUL, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, "mul32_3x2");

    issue(FMT_FP32, OP_MUL, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, "mul32_rne_sticky");
    issue(FMT_FP32, OP_MUL, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, "mul32_neg");
    issue(FMT_FP32, OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, "add32_1p1");
    issue(FMT_FP32, OP_SUB, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, "sub32_cancel");
    issue(FMT_FP16, OP_MUL, 32'h0000_4000, 32'h0000_4200, 32'h0000_4600, "mul16_2x3");
    issue(FMT_FP16, OP_ADD, 32'h0000_3C00, 32'h0000_3C00, 32'h0000_4000, "add16_1p1");
    issue(FMT_FP32, OP_MUL, 32'h7F00_0000, 32'h4080_0000, 32'h7F80_0000, "mul32_overflow");
    issue(FMT_FP32, OP_MUL, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, "mul32_nan");
    issue(FMT_FP32, OP_MUL, 32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, "mul32_daz");
    issue(FMT_FP32, OP_MUL, 32'h8080_0000, 32'h3F00_0000, 32'h8000_0000, "mul32_ftz");
    issue(FMT_FP32, OP_ADD, 32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, "add32_tie_even");
    issue(FMT_FP32, OP_ADD, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, "add32_tie_odd");
    issue(FMT_FP32, OP_ADD, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, "add32_tie_down");
    issue(FMT_FP32, OP_SUB, 32'h4B80_0000, 32'h3F80_0000, 32'h4B7F_FFFF, "sub32_renorm");
    issue(FMT_FP32, OP_SUB, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, "sub32_3m1");
    issue(FMT_FP32, OP_SUB, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, "sub32_swap");
    issue(FMT_FP32, OP_ADD, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, "add32_inf_m_inf");
    issue(FMT_FP32, OP_MUL, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, "mul32_inf_x_0");
    issue(FMT_FP32, OP_MUL, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, "mul32_inf_prop");
    issue(FMT_FP32, OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, "add32_negzeros");
    issue(FMT_FP32, OP_ADD, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000, "add32_cancel_pos");
    issue(FMT_FP32, OP_ADD, 32'h0000_0000, 32'hC040_0000, 32'hC040_0000, "add32_zero_op");
    issue(FMT_FP16, OP_ADD, 32'hABCD_3C00, 32'h1234_3C00, 32'h0000_4000, "add16_upper_ignored");
    issue(FMT_FP16, OP_SUB, 32'h0000_4200, 32'h0000_3C00, 32'h0000_4000, "sub16_3m1");
    issue(FMT_FP16, OP_MUL, 32'h0000_7800, 32'h0000_4000, 32'h0000_7C00, "mul16_overflow");
    issue(FMT_FP16, OP_MUL, 32'h0000_7C00, 32'h0000_0000, 32'h0000_7E00, "mul16_nan");
    issue(FMT_FP32, fp_op_e'(2'd3), 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, "bad_opcode");
    issue(fp_fmt_e'(2'd2), OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, "bad_fmt_as_fp32");

    // Mid-stream asynchronous reset: R must clear without waiting for an edge.
    issue(FMT_FP32, OP_MUL, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, "pre_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", R, 32'h0);
    issue(FMT_FP32, OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 32'h0, "reset_hold_0");
    issue(FMT_FP16, OP_MUL, 32'h0000_4000, 32'h0000_4200, 32'h0, "reset_hold_1");
    @(negedge clk);
    rst_n = 1'b1;
    drive_push(FMT_FP32, OP_SUB, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, "after_release");

    for (int i = 0; i < 4000; i++) begin
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(8'h40, 8'h7A)), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 8'($urandom_range(8'h40, 8'h7A)), 23'($urandom)};
      issue(FMT_FP32, OP_MUL, a, b, ref_mul32(a, b), "rand_mul32");
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
